// File: rtl/mux_scan_ctrl.sv
// Purpose: sequences an 8:1 bit mux over the enabled channels and packs the samples into a word.
// Latency: valid rises K*(SETTLE+1) cycles after an accepted start (K = enabled channels, 1 cycle if none).
// Backpressure: word/valid held while valid && !ready; start is ignored until back in IDLE.
module mux_scan_ctrl #(
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             mux_y,
  output logic [SEL_W-1:0] mux_s,
  output logic             mux_e,
  output logic [N_CH-1:0]  word,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state;
  state_t           state_nxt;
  logic [N_CH-1:0]  mask;
  logic [3:0]       cnt;
  logic             sample_hit;

  logic             first_found;
  logic [SEL_W-1:0] first_idx;
  logic             next_found;
  logic [SEL_W-1:0] next_idx;

  logic             mux_e_nxt;
  logic             valid_nxt;
  logic             busy_nxt;

  assign sample_hit = (cnt == SETTLE_C);

  // Lowest set bit of the incoming mask: the first channel a new scan selects.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(k);
      end
    end
  end

  // Next set bit of the captured mask strictly above the current select (no wrap).
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(mux_s))) begin
        next_found = 1'b1;
        next_idx   = SEL_W'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: an empty mask skips SCAN and completes immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = first_found ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (sample_hit && !next_found) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (valid && ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state, so the flags below are registered alongside it.
  always_comb begin
    mux_e_nxt = (state_nxt == SCAN);
    valid_nxt = (state_nxt == DONE);
    busy_nxt  = (state_nxt != IDLE);
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_e <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      mux_e <= mux_e_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
    end
  end

  // Datapath: mask capture, settle counter, select stepping and sample assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask  <= '0;
      cnt   <= '0;
      mux_s <= '0;
      word  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask <= ch_mask;
            word <= '0;
            cnt  <= '0;
            if (first_found) begin
              mux_s <= first_idx;
            end
          end
        end
        SCAN: begin
          if (sample_hit) begin
            word[mux_s] <= mux_y;
            cnt         <= '0;
            if (next_found) begin
              mux_s <= next_idx;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          // DONE holds word and select until the handshake completes.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Purpose: directed checks of mux_scan_ctrl against a behavioural 8:1 mux with i=8'b10111011.
// Latency: SETTLE=1, so each enabled channel takes two cycles.
// Backpressure: ready is held low to confirm word/valid stability and start rejection.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] ch_mask;
  logic       mux_y;
  logic [2:0] mux_s;
  logic       mux_e;
  logic [7:0] word;
  logic       valid;
  logic       ready;
  logic       busy;

  logic [7:0] mux_in;
  int         errors;
  int         checks;

  mux_scan_ctrl #(.N_CH(8), .SEL_W(3), .SETTLE(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ch_mask (ch_mask),
    .mux_y   (mux_y),
    .mux_s   (mux_s),
    .mux_e   (mux_e),
    .word    (word),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8:1 mux fed by the controller.
  assign mux_y = mux_e ? mux_in[mux_s] : 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_s"},     8'(mux_s), 8'h00);
    chk({tag, "_e"},     8'(mux_e), 8'h00);
    chk({tag, "_word"},  word,      8'h00);
    chk({tag, "_valid"}, 8'(valid), 8'h00);
    chk({tag, "_busy"},  8'(busy),  8'h00);
  endtask

  // Start a scan with mask m; lat is the hand-computed number of edges after E0 until valid.
  task automatic scan(input string tag, input logic [7:0] m, input logic [7:0] exp_word, input int lat);
    int bits[8];
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        bits[n] = k;
        n++;
      end
    end
    ch_mask = m;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    ch_mask = ~m;   // changes after capture must not affect the scan
    if (n > 0) begin
      chk({tag, "_e0_sel"}, 8'(mux_s), 8'(bits[0]));
      chk({tag, "_e0_en"},  8'(mux_e), 8'h01);
      chk({tag, "_e0_busy"}, 8'(busy), 8'h01);
      for (int c = 1; c < lat; c++) begin
        tick();
        chk({tag, "_sel"},   8'(mux_s), 8'(bits[c / 2]));
        chk({tag, "_en"},    8'(mux_e), 8'h01);
        chk({tag, "_early"}, 8'(valid), 8'h00);
      end
      tick();
    end
    chk({tag, "_valid"}, 8'(valid), 8'h01);
    chk({tag, "_word"},  word,      exp_word);
    chk({tag, "_en_off"}, 8'(mux_e), 8'h00);
    chk({tag, "_busy"},  8'(busy),  8'h01);
  endtask

  task automatic accept(input string tag, input logic [7:0] exp_word);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk({tag, "_valid"}, 8'(valid), 8'h00);
    chk({tag, "_busy"},  8'(busy),  8'h00);
    chk({tag, "_word"},  word,      exp_word);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    mux_in  = 8'b10111011;
    rst     = 1'b1;
    start   = 1'b0;
    ch_mask = 8'h00;
    ready   = 1'b0;

    // Reset state
    #3;
    chk_idle_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle_zero("post_reset");

    // Full scan
    scan("full", 8'hFF, 8'hBB, 16);
    accept("full_acc", 8'hBB);

    // Sparse mask: channels 0 and 7
    scan("sparse", 8'h81, 8'h81, 4);
    chk("sparse_s_hold", 8'(mux_s), 8'h07);
    accept("sparse_acc", 8'h81);

    // Low nibble: bits 7:4 stay zero
    scan("nib", 8'h0F, 8'h0B, 8);
    accept("nib_acc", 8'h0B);

    // Empty mask: valid straight after start, mux never enabled
    scan("empty", 8'h00, 8'h00, 0);
    accept("empty_acc", 8'h00);

    // Backpressure: hold ready low, pulse start, toggle mask
    scan("bp", 8'hFF, 8'hBB, 16);
    for (int c = 0; c < 5; c++) begin
      start   = (c % 2 == 0);
      ch_mask = 8'(c * 37 + 1);
      tick();
      chk("bp_valid", 8'(valid), 8'h01);
      chk("bp_word",  word,      8'hBB);
      chk("bp_busy",  8'(busy),  8'h01);
      chk("bp_en",    8'(mux_e), 8'h00);
    end
    start = 1'b1;   // coincides with the handshake: must be ignored
    ready = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    chk("bp_rel_valid", 8'(valid), 8'h00);
    chk("bp_rel_busy",  8'(busy),  8'h00);
    tick();
    chk("bp_no_scan_busy", 8'(busy),  8'h00);
    chk("bp_no_scan_en",   8'(mux_e), 8'h00);
    chk("bp_word_kept",    word,      8'hBB);
    scan("bp2", 8'h02, 8'h02, 2);
    accept("bp2_acc", 8'h02);

    // Reset mid-scan while mux_s=3
    ch_mask = 8'hFF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("mid_sel3", 8'(mux_s), 8'h03);
    chk("mid_en",   8'(mux_e), 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_idle_zero("rst_release");
    scan("after_rst", 8'hFF, 8'hBB, 16);
    accept("after_rst_acc", 8'hBB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
